// File: rtl/pll_supervisor.sv
// rtl/pll_supervisor.sv - PLL reset/lock sequencer with staggered downstream reset release
// and runtime output-divider reprogramming applied only while the PLL is held in reset.
module pll_supervisor #(
  parameter int NUM_RST      = 3,
  parameter int DIVW         = 7,
  parameter int DEF_DIV      = 6,
  parameter int PLL_RST_CYC  = 16,
  parameter int LOCK_FILTER  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 3,
  parameter int STAGGER      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_lock,
  output logic               pll_rst,
  output logic [DIVW-1:0]    odiv,
  input  logic               sel_req,
  input  logic [DIVW-1:0]    sel_div,
  output logic               sel_ack,
  output logic [NUM_RST-1:0] rst_out,
  output logic               ready,
  output logic               fail
);
  localparam int RW       = $clog2(PLL_RST_CYC + 1);
  localparam int FW       = $clog2(LOCK_FILTER + 1);
  localparam int TW       = $clog2(LOCK_TIMEOUT + 1);
  localparam int NW       = $clog2(MAX_RETRY + 1);
  localparam int REL_LAST = STAGGER * (NUM_RST - 1);
  localparam int LW       = $clog2(REL_LAST + 2);

  localparam logic [RW-1:0] RST_LAST   = RW'(PLL_RST_CYC - 1);
  localparam logic [FW-1:0] FILT_LAST  = FW'(LOCK_FILTER - 1);
  localparam logic [FW-1:0] FILT_MAX   = FW'(LOCK_FILTER);
  localparam logic [TW-1:0] TMO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MAX    = TW'(LOCK_TIMEOUT);
  localparam logic [NW-1:0] RETRY_LAST = NW'(MAX_RETRY - 1);
  localparam logic [LW-1:0] REL_END    = LW'(REL_LAST);

  typedef enum logic [2:0] {S_RST_PLL, S_WAIT_LOCK, S_RELEASE, S_RUN, S_FAIL} state_t;

  state_t              state_q, state_d;
  logic [RW-1:0]       rst_cnt_q, rst_cnt_d;
  logic [FW-1:0]       filt_q, filt_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [NW-1:0]       retry_q, retry_d;
  logic [LW-1:0]       rel_q, rel_d;
  logic                pll_rst_q, pll_rst_d;
  logic [NUM_RST-1:0]  rst_out_q, rst_out_d;
  logic                ready_q, ready_d;
  logic                fail_q, fail_d;
  logic                sel_ack_q, sel_ack_d;
  logic [DIVW-1:0]     odiv_q, odiv_d;
  logic                lock_m_q, lock_s_q;
  logic                to_rst;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    filt_d    = filt_q;
    tmo_d     = tmo_q;
    retry_d   = retry_q;
    rel_d     = rel_q;
    pll_rst_d = pll_rst_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    fail_d    = fail_q;
    sel_ack_d = 1'b0;
    odiv_d    = odiv_q;
    to_rst    = 1'b0;
    unique case (state_q)
      S_RST_PLL: begin
        pll_rst_d = 1'b1;
        filt_d    = '0;
        tmo_d     = '0;
        if (rst_cnt_q >= RST_LAST) begin
          state_d   = S_WAIT_LOCK;
          pll_rst_d = 1'b0;
          rst_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        filt_d = !lock_s_q ? '0 : (filt_q == FILT_MAX) ? filt_q : filt_q + 1'b1;
        tmo_d  = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
        // A completed filter wins over a timeout landing on the same cycle.
        if (lock_s_q && filt_q == FILT_LAST) begin
          retry_d      = '0;
          rel_d        = '0;
          rst_out_d[0] = 1'b0;
          state_d      = (REL_LAST == 0) ? S_RUN : S_RELEASE;
        end else if (tmo_q == TMO_LAST) begin
          retry_d = retry_q + 1'b1;
          if (retry_q == RETRY_LAST) begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
          end else begin
            to_rst = 1'b1;
          end
        end
      end
      S_RELEASE: begin
        if (!lock_s_q) begin
          to_rst = 1'b1;
        end else begin
          rel_d = rel_q + 1'b1;
          for (int i = 1; i < NUM_RST; i++) begin
            if (rel_d == LW'(STAGGER * i)) rst_out_d[i] = 1'b0;
          end
          if (rel_d == REL_END) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!lock_s_q) begin
          to_rst = 1'b1;
        end else if (sel_req) begin
          sel_ack_d = 1'b1;
          odiv_d    = sel_div;
          to_rst    = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
      end
      S_FAIL: begin
        pll_rst_d = 1'b0;
        rst_out_d = '1;
        fail_d    = 1'b1;
        if (sel_req) begin
          sel_ack_d = 1'b1;
          odiv_d    = sel_div;
          fail_d    = 1'b0;
          retry_d   = '0;
          to_rst    = 1'b1;
        end
      end
      default: to_rst = 1'b1;
    endcase
    // Every path back to RST_PLL raises pll_rst on the same edge any new odiv lands.
    if (to_rst) begin
      state_d   = S_RST_PLL;
      pll_rst_d = 1'b1;
      rst_cnt_d = '0;
      rst_out_d = '1;
      ready_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RST_PLL;
      rst_cnt_q <= '0;
      filt_q    <= '0;
      tmo_q     <= '0;
      retry_q   <= '0;
      rel_q     <= '0;
      pll_rst_q <= 1'b1;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      sel_ack_q <= 1'b0;
      odiv_q    <= DIVW'(DEF_DIV);
      lock_m_q  <= 1'b0;
      lock_s_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      filt_q    <= filt_d;
      tmo_q     <= tmo_d;
      retry_q   <= retry_d;
      rel_q     <= rel_d;
      pll_rst_q <= pll_rst_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
      sel_ack_q <= sel_ack_d;
      odiv_q    <= odiv_d;
      lock_m_q  <= pll_lock;
      lock_s_q  <= lock_m_q;
    end
  end

  assign pll_rst = pll_rst_q;
  assign rst_out = rst_out_q;
  assign ready   = ready_q;
  assign fail    = fail_q;
  assign sel_ack = sel_ack_q;
  assign odiv    = odiv_q;
endmodule

// File: tb/tb_pll_supervisor.sv
// tb/tb_pll_supervisor.sv - randomized self-checking bench for pll_supervisor
// against a timestamp-based behavioural model plus directed timing checks.
module tb_pll_supervisor;
  localparam int NR = 3, DW = 7, DEFD = 6, PRC = 16, LF = 40, LT = 300, MR = 3, ST = 4;

  logic clk = 1'b0, reset = 1'b1, pll_lock = 1'b0, sel_req = 1'b0;
  logic [DW-1:0] sel_div = '0;
  logic pll_rst, sel_ack, ready, fail;
  logic [DW-1:0] odiv;
  logic [NR-1:0] rst_out;

  always #5 clk = ~clk;

  pll_supervisor #(
    .NUM_RST(NR), .DIVW(DW), .DEF_DIV(DEFD), .PLL_RST_CYC(PRC), .LOCK_FILTER(LF),
    .LOCK_TIMEOUT(LT), .MAX_RETRY(MR), .STAGGER(ST)
  ) dut (
    .clk(clk), .reset(reset), .pll_lock(pll_lock), .pll_rst(pll_rst), .odiv(odiv),
    .sel_req(sel_req), .sel_div(sel_div), .sel_ack(sel_ack), .rst_out(rst_out),
    .ready(ready), .fail(fail)
  );

  int n_cmp = 0, n_bad = 0;
  int t = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, t);
    end
  endtask

  // Model: phases with entry timestamps; elapsed time decides every transition.
  typedef enum {M_RSTPLL, M_WAIT, M_REL, M_RUN, M_FAIL} mph_t;
  mph_t ph;
  int t_ent, run_len, retries;
  bit lk1, lk2;
  bit e_pll_rst, e_ready, e_fail, e_ack;
  bit [NR-1:0] e_rst;
  bit [DW-1:0] e_odiv;

  task automatic model_reset();
    t = 0; t_ent = 0; ph = M_RSTPLL; lk1 = 0; lk2 = 0; run_len = 0; retries = 0;
    e_pll_rst = 1; e_rst = '1; e_ready = 0; e_fail = 0; e_ack = 0; e_odiv = DEFD;
  endtask

  task automatic to_rstpll();
    ph = M_RSTPLL; t_ent = t; e_pll_rst = 1; e_rst = '1; e_ready = 0;
  endtask

  task automatic rel_update(input int el);
    for (int i = 0; i < NR; i++) e_rst[i] = (el < ST * i);
    if (el >= ST * (NR - 1)) begin ph = M_RUN; t_ent = t; end
  endtask

  task automatic model_step();
    bit ls;
    int el;
    ls = lk2; lk2 = lk1; lk1 = pll_lock;
    el = t - t_ent;
    e_ack = 0;
    case (ph)
      M_RSTPLL: if (el == PRC) begin ph = M_WAIT; t_ent = t; e_pll_rst = 0; run_len = 0; end
      M_WAIT: begin
        run_len = ls ? run_len + 1 : 0;
        if (run_len == LF) begin
          retries = 0; ph = M_REL; t_ent = t; rel_update(0);
        end else if (el == LT) begin
          retries++;
          if (retries == MR) begin ph = M_FAIL; e_fail = 1; end
          else to_rstpll();
        end
      end
      M_REL: if (!ls) to_rstpll(); else rel_update(el);
      M_RUN: begin
        if (!ls) to_rstpll();
        else if (sel_req) begin e_ack = 1; e_odiv = sel_div; to_rstpll(); end
        else e_ready = 1;
      end
      M_FAIL: if (sel_req) begin
        e_ack = 1; e_odiv = sel_div; e_fail = 0; retries = 0; to_rstpll();
      end
      default: ;
    endcase
  endtask

  // Observed event times (DUT side) for directed timing checks.
  int t_pll_fall, t_pll_fall_last, n_pll_fall, t_fail, t_ready, t_ack, n_ack;
  int t_rst_fall [NR];
  bit p_pll_rst, p_ready, p_fail;
  bit [NR-1:0] p_rst;

  task automatic clear_events();
    t_pll_fall = -1; t_pll_fall_last = -1; n_pll_fall = 0; t_fail = -1; t_ready = -1;
    t_ack = -1; n_ack = 0;
    for (int i = 0; i < NR; i++) t_rst_fall[i] = -1;
    p_pll_rst = 1; p_ready = 0; p_fail = 0; p_rst = '1;
  endtask

  task automatic tick();
    @(posedge clk);
    t++;
    model_step();
    @(negedge clk);
    chk("pll_rst", 32'(pll_rst), 32'(e_pll_rst));
    chk("rst_out", 32'(rst_out), 32'(e_rst));
    chk("ready", 32'(ready), 32'(e_ready));
    chk("fail", 32'(fail), 32'(e_fail));
    chk("sel_ack", 32'(sel_ack), 32'(e_ack));
    chk("odiv", 32'(odiv), 32'(e_odiv));
    if (p_pll_rst && !pll_rst) begin
      if (t_pll_fall < 0) t_pll_fall = t;
      t_pll_fall_last = t; n_pll_fall++;
    end
    for (int i = 0; i < NR; i++) if (p_rst[i] && !rst_out[i]) t_rst_fall[i] = t;
    if (!p_ready && ready) t_ready = t;
    if (!p_fail && fail) t_fail = t;
    if (sel_ack) begin n_ack++; t_ack = t; end
    p_pll_rst = pll_rst; p_ready = ready; p_fail = fail; p_rst = rst_out;
    if (e_ack) sel_req = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // which: 0 ready, 1 fail, 2 sel_ack, 3 rst_out[0] low, 4 pll_rst low
  task automatic wait_for(input int which, input int budget, input string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      case (which)
        0: hit = ready;
        1: hit = fail;
        2: hit = sel_ack;
        3: hit = !rst_out[0];
        default: hit = !pll_rst;
      endcase
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    chk({tag, "_rst_out"}, 32'(rst_out), 32'd7);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_fail"}, 32'(fail), 32'd0);
    chk({tag, "_sel_ack"}, 32'(sel_ack), 32'd0);
    chk({tag, "_odiv"}, 32'(odiv), 32'(DEFD));
  endtask

  task automatic do_reset();
    reset = 1'b1; sel_req = 1'b0; pll_lock = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("rst");
    model_reset();
    clear_events();
    reset = 1'b0;
  endtask

  int t0, g1, t_req, t_e0;

  initial begin
    do_reset();

    // Clean bring-up, lock 100 cycles after pll_rst falls.
    run(PRC + 100);
    chk("a_pll_fall", t_pll_fall, PRC);
    pll_lock = 1'b1; t0 = t;
    wait_for(0, LF + 4 * ST * NR + 20, "a_wait_ready");
    chk("a_rst0", t_rst_fall[0], t0 + LF + 2);
    chk("a_rst1", t_rst_fall[1], t0 + LF + 2 + ST);
    chk("a_rst2", t_rst_fall[2], t0 + LF + 2 + 2 * ST);
    chk("a_ready", t_ready, t0 + LF + 2 + 2 * ST + 1);

    // One-cycle glitch partway through the filter restarts it.
    do_reset();
    run(PRC + 20);
    pll_lock = 1'b1; t0 = t;
    run(2 + LF - 10);
    pll_lock = 1'b0;
    run(1);
    pll_lock = 1'b1; g1 = t;
    wait_for(0, 2 * LF + 4 * ST * NR, "b_wait_ready");
    chk("b_rst0", t_rst_fall[0], g1 + LF + 2);

    // No lock at all: retries exhaust, then a divider request clears FAIL.
    do_reset();
    wait_for(1, MR * (PRC + LT) + 50, "c_wait_fail");
    chk("c_fail_t", t_fail, MR * (PRC + LT));
    chk("c_attempts", n_pll_fall, MR);
    chk("c_pll_rst", 32'(pll_rst), 32'd0);
    chk("c_rst_out", 32'(rst_out), 32'd7);
    sel_req = 1'b1; sel_div = 7'd8; t_req = t;
    wait_for(2, 10, "c_wait_ack");
    chk("c_ack_lat", t_ack - t_req, 1);
    chk("c_odiv", 32'(odiv), 32'd8);
    chk("c_fail_clr", 32'(fail), 32'd0);

    // Divider change while running.
    pll_lock = 1'b1;
    wait_for(0, 2 * (PRC + LF) + 4 * ST * NR, "d_wait_ready");
    sel_req = 1'b1; sel_div = 7'd12; n_ack = 0;
    run(1);
    chk("d_ack", 32'(sel_ack), 32'd1);
    chk("d_odiv", 32'(odiv), 32'd12);
    chk("d_rst_out", 32'(rst_out), 32'd7);
    chk("d_ready", 32'(ready), 32'd0);
    chk("d_pll_rst", 32'(pll_rst), 32'd1);
    t_req = t;
    wait_for(4, PRC + 4, "d_wait_pll_fall");
    chk("d_pll_hold", t_pll_fall_last - t_req, PRC);
    wait_for(0, 2 * (PRC + LF) + 4 * ST * NR, "d_wait_ready2");
    chk("d_ack_once", n_ack, 1);
    chk("d_order", 32'(t_rst_fall[0] < t_rst_fall[1] && t_rst_fall[1] < t_rst_fall[2]), 32'd1);

    // Lock loss coincides (after sync) with a request: loss wins, ack waits for next RUN.
    pll_lock = 1'b0; t_e0 = t;
    run(2);
    sel_req = 1'b1; sel_div = 7'd20; n_ack = 0;
    run(1);
    chk("e_no_ack", 32'(sel_ack), 32'd0);
    chk("e_rst_out", 32'(rst_out), 32'd7);
    chk("e_odiv_kept", 32'(odiv), 32'd12);
    run(5);
    pll_lock = 1'b1;
    wait_for(2, 2 * (PRC + LF) + 4 * ST * NR, "e_wait_ack");
    chk("e_odiv_new", 32'(odiv), 32'd20);
    chk("e_ack_once", n_ack, 1);
    chk("e_ack_t", t_ack, t_rst_fall[2] + 1);
    chk("e_rereleased", 32'(t_rst_fall[2] > t_e0), 32'd1);

    // Random lock activity and divider requests, checked cycle by cycle.
    for (int seg = 0; seg < 120; seg++) begin
      case ($urandom_range(0, 5))
        0: pll_lock = 1'b0;
        1: begin pll_lock = 1'b0; run(1); pll_lock = 1'b1; end
        2: if (!sel_req) begin sel_req = 1'b1; sel_div = 7'($urandom_range(0, 127)); end
        default: pll_lock = 1'b1;
      endcase
      run($urandom_range(1, 90));
      if (seg == 60) do_reset();
    end

    // Asynchronous reset while RELEASE has already cleared rst_out[0].
    do_reset();
    run(PRC + 5);
    pll_lock = 1'b1;
    wait_for(3, LF + 20, "g_wait_rst0");
    run(1);
    chk("g_pre_rst0", 32'(rst_out), 32'd6);
    #2 reset = 1'b1;
    #1 check_reset_values("g_async");
    do_reset();
    run(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
